// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush and an
// optional skid entry that makes in_ready a pure flop output.
//
// Ports:
//   clk, resetn         clock, async active-low reset
//   flush               sync squash of all held entries
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data head payload
//   level               number of valid entries held (0..2)
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               SKID      = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       level
);

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_BUSY  = 2'b10;
   localparam logic [1:0] ST_FULL  = 2'b11;

   logic             m_valid_q, m_valid_d;
   logic             s_valid_q, s_valid_d;
   logic [WIDTH-1:0] m_data_q,  m_data_d;
   logic [WIDTH-1:0] s_data_q,  s_data_d;
   logic             in_fire;
   logic             out_fire;

   // Skid mode: ready comes straight from the skid flop, so no
   // combinational path exists from out_ready back to in_ready.
   assign in_ready  = SKID ? !s_valid_q : (!m_valid_q | out_ready);
   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign level     = {1'b0, m_valid_q} + {1'b0, s_valid_q};
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = m_valid_q & out_ready;

   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      if (flush) begin
         // Data registers keep their contents; only validity is cleared.
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!SKID) begin
         m_valid_d = in_fire | (m_valid_q & !out_fire);
         if (in_fire) m_data_d = in_data;
      end else begin
         case ({m_valid_q, s_valid_q})
            ST_EMPTY: begin
               if (in_fire) begin
                  m_valid_d = 1'b1;
                  m_data_d  = in_data;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  m_data_d = in_data;
               end else if (in_fire) begin
                  s_valid_d = 1'b1;
                  s_data_d  = in_data;
               end else if (out_fire) begin
                  m_valid_d = 1'b0;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  m_data_d  = s_data_q;
                  s_valid_d = 1'b0;
               end
            end
            default: begin
               m_valid_d = m_valid_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_data_q  <= RESET_VAL;
         s_data_q  <= RESET_VAL;
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_data_q  <= m_data_d;
         s_data_q  <= s_data_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg,
// one instance in skid mode (a) and one in single-entry mode (b).
module tb_pipe_stage_reg;

   localparam logic [31:0] RV_A = 32'h0000_0000;
   localparam logic [31:0] RV_B = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [31:0] in_data_a, out_data_a;
   logic [1:0]  level_a;
   logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [31:0] in_data_b, out_data_b;
   logic [1:0]  level_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_A), .SKID(1'b1)) dut_a (
      .clk(clk), .resetn(resetn), .flush(flush_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_data(out_data_a), .level(level_a)
   );

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_B), .SKID(1'b0)) dut_b (
      .clk(clk), .resetn(resetn), .flush(flush_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_data(out_data_b), .level(level_b)
   );

   task automatic idle_inputs();
      flush_a = 0; in_valid_a = 0; out_ready_a = 0; in_data_a = '0;
      flush_b = 0; in_valid_b = 0; out_ready_b = 0; in_data_b = '0;
   endtask

   task automatic squash();
      @(negedge clk);
      idle_inputs();
      flush_a = 1; flush_b = 1;
      @(posedge clk);
      #1;
      flush_a = 0; flush_b = 0;
   endtask

   task automatic test_reset();
      resetn = 0;
      idle_inputs();
      in_valid_a = 1; in_data_a = 32'hAAAA5555;
      in_valid_b = 1; in_data_b = 32'hAAAA5555;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || out_data_a !== RV_A || level_a !== 2'd0 || in_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL reset_a: v=%b d=%h lvl=%0d rdy=%b want v=0 d=%h lvl=0 rdy=1",
                  out_valid_a, out_data_a, level_a, in_ready_a, RV_A);
      end
      checks++;
      if (out_valid_b !== 1'b0 || out_data_b !== RV_B || level_b !== 2'd0 || in_ready_b !== 1'b1) begin
         failures++;
         $display("FAIL reset_b: v=%b d=%h lvl=%0d rdy=%b want v=0 d=%h lvl=0 rdy=1",
                  out_valid_b, out_data_b, level_b, in_ready_b, RV_B);
      end
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== 32'hAAAA5555) begin
         failures++;
         $display("FAIL reset_release_a: v=%b d=%h want v=1 d=aaaa5555", out_valid_a, out_data_a);
      end
      checks++;
      if (out_valid_b !== 1'b1 || out_data_b !== 32'hAAAA5555) begin
         failures++;
         $display("FAIL reset_release_b: v=%b d=%h want v=1 d=aaaa5555", out_valid_b, out_data_b);
      end
      in_valid_a = 0; in_valid_b = 0;
      squash();
   endtask

   task automatic test_streaming();
      @(negedge clk);
      out_ready_a = 1;
      for (int k = 0; k < 4; k++) begin
         in_valid_a = 1; in_data_a = 32'(k + 1);
         @(posedge clk);
         #1;
         checks++;
         if (out_valid_a !== 1'b1 || out_data_a !== 32'(k + 1) || level_a !== 2'd1 || in_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL stream_%0d: v=%b d=%h lvl=%0d rdy=%b want v=1 d=%h lvl=1 rdy=1",
                     k, out_valid_a, out_data_a, level_a, in_ready_a, k + 1);
         end
         @(negedge clk);
      end
      in_valid_a = 0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || level_a !== 2'd0) begin
         failures++;
         $display("FAIL stream_drain: v=%b lvl=%0d want v=0 lvl=0", out_valid_a, level_a);
      end
      @(negedge clk);
      out_ready_a = 0;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready_a = 0;
      in_valid_a = 1; in_data_a = 32'h10;
      @(negedge clk);
      in_data_a = 32'h11;
      @(negedge clk);
      in_data_a = 32'h12;
      #1;
      checks++;
      if (level_a !== 2'd2 || in_ready_a !== 1'b0 || out_data_a !== 32'h10) begin
         failures++;
         $display("FAIL bp_full: lvl=%0d rdy=%b d=%h want lvl=2 rdy=0 d=10",
                  level_a, in_ready_a, out_data_a);
      end
      @(posedge clk);
      #1;
      checks++;
      if (level_a !== 2'd2 || out_data_a !== 32'h10) begin
         failures++;
         $display("FAIL bp_hold: lvl=%0d d=%h want lvl=2 d=10", level_a, out_data_a);
      end
      @(negedge clk);
      out_ready_a = 1;
      @(posedge clk);
      #1;
      checks++;
      if (out_data_a !== 32'h11 || level_a !== 2'd1 || in_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL bp_pop1: d=%h lvl=%0d rdy=%b want d=11 lvl=1 rdy=1",
                  out_data_a, level_a, in_ready_a);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_data_a !== 32'h12 || out_valid_a !== 1'b1 || level_a !== 2'd1) begin
         failures++;
         $display("FAIL bp_pop2: d=%h v=%b lvl=%0d want d=12 v=1 lvl=1",
                  out_data_a, out_valid_a, level_a);
      end
      @(negedge clk);
      in_valid_a = 0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || level_a !== 2'd0) begin
         failures++;
         $display("FAIL bp_empty: v=%b lvl=%0d want v=0 lvl=0", out_valid_a, level_a);
      end
      @(negedge clk);
      out_ready_a = 0;
   endtask

   task automatic test_flush();
      @(negedge clk);
      out_ready_a = 0;
      in_valid_a = 1; in_data_a = 32'h20;
      @(negedge clk);
      in_data_a = 32'h21;
      @(negedge clk);
      flush_a = 1; in_data_a = 32'h99;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || level_a !== 2'd0 || in_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL flush_clear: v=%b lvl=%0d rdy=%b want v=0 lvl=0 rdy=1",
                  out_valid_a, level_a, in_ready_a);
      end
      @(negedge clk);
      flush_a = 0; in_valid_a = 0; out_ready_a = 1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || out_data_a !== 32'h20) begin
         failures++;
         $display("FAIL flush_after: v=%b d=%h want v=0 d=20", out_valid_a, out_data_a);
      end
      @(negedge clk);
      out_ready_a = 0;
   endtask

   task automatic test_noskid();
      @(negedge clk);
      out_ready_b = 0;
      in_valid_b = 1; in_data_b = 32'h5;
      @(negedge clk);
      in_data_b = 32'h7;
      #1;
      checks++;
      if (in_ready_b !== 1'b0 || level_b !== 2'd1 || out_data_b !== 32'h5) begin
         failures++;
         $display("FAIL noskid_stall: rdy=%b lvl=%0d d=%h want rdy=0 lvl=1 d=5",
                  in_ready_b, level_b, out_data_b);
      end
      out_ready_b = 1;
      #1;
      checks++;
      if (in_ready_b !== 1'b1) begin
         failures++;
         $display("FAIL noskid_comb_ready: rdy=%b want 1", in_ready_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_data_b !== 32'h7 || out_valid_b !== 1'b1 || level_b !== 2'd1) begin
         failures++;
         $display("FAIL noskid_pass: d=%h v=%b lvl=%0d want d=7 v=1 lvl=1",
                  out_data_b, out_valid_b, level_b);
      end
      @(negedge clk);
      in_valid_b = 0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_b !== 1'b0 || level_b !== 2'd0) begin
         failures++;
         $display("FAIL noskid_empty: v=%b lvl=%0d want v=0 lvl=0", out_valid_b, level_b);
      end
      @(negedge clk);
      out_ready_b = 0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      in_valid_a = 1; in_data_a = 32'h31;
      in_valid_b = 1; in_data_b = 32'h41;
      @(posedge clk);
      #2;
      in_valid_a = 0; in_valid_b = 0;
      resetn = 0;
      #1;
      checks++;
      if (out_valid_a !== 1'b0 || out_data_a !== RV_A || level_a !== 2'd0 || in_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_a: v=%b d=%h lvl=%0d rdy=%b", out_valid_a, out_data_a, level_a, in_ready_a);
      end
      checks++;
      if (out_valid_b !== 1'b0 || out_data_b !== RV_B || level_b !== 2'd0 || in_ready_b !== 1'b1) begin
         failures++;
         $display("FAIL async_reset_b: v=%b d=%h lvl=%0d rdy=%b", out_valid_b, out_data_b, level_b, in_ready_b);
      end
      @(negedge clk);
      resetn = 1;
   endtask

   task automatic test_random(input int n);
      logic [31:0] qa[$];
      logic [31:0] qb[$];
      logic        era, erb, ifa, ofa, ifb, ofb;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         flush_a     = ($urandom_range(63) == 0);
         in_valid_a  = ($urandom_range(9) < 7);
         in_data_a   = $urandom;
         out_ready_a = ($urandom_range(9) < 6);
         flush_b     = ($urandom_range(63) == 0);
         in_valid_b  = ($urandom_range(9) < 7);
         in_data_b   = $urandom;
         out_ready_b = ($urandom_range(9) < 6);
         #1;
         era = (qa.size() < 2);
         erb = (qb.size() == 0) || out_ready_b;
         checks++;
         if (in_ready_a !== era || out_valid_a !== (qa.size() != 0) || level_a !== 2'(qa.size())) begin
            failures++;
            $display("FAIL rand_a_ctl cyc=%0d: rdy=%b v=%b lvl=%0d want rdy=%b n=%0d",
                     i, in_ready_a, out_valid_a, level_a, era, qa.size());
         end
         if (qa.size() != 0) begin
            checks++;
            if (out_data_a !== qa[0]) begin
               failures++;
               $display("FAIL rand_a_data cyc=%0d: d=%h want %h", i, out_data_a, qa[0]);
            end
         end
         checks++;
         if (in_ready_b !== erb || out_valid_b !== (qb.size() != 0) || level_b !== 2'(qb.size())) begin
            failures++;
            $display("FAIL rand_b_ctl cyc=%0d: rdy=%b v=%b lvl=%0d want rdy=%b n=%0d",
                     i, in_ready_b, out_valid_b, level_b, erb, qb.size());
         end
         if (qb.size() != 0) begin
            checks++;
            if (out_data_b !== qb[0]) begin
               failures++;
               $display("FAIL rand_b_data cyc=%0d: d=%h want %h", i, out_data_b, qb[0]);
            end
         end
         ifa = in_valid_a & era;
         ofa = (qa.size() != 0) & out_ready_a;
         ifb = in_valid_b & erb;
         ofb = (qb.size() != 0) & out_ready_b;
         @(posedge clk);
         if (flush_a) qa.delete();
         else begin
            if (ofa) void'(qa.pop_front());
            if (ifa) qa.push_back(in_data_a);
         end
         if (flush_b) qb.delete();
         else begin
            if (ofb) void'(qb.pop_front());
            if (ifb) qb.push_back(in_data_b);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      test_reset();
      test_streaming();
      test_backpressure();
      squash();
      test_flush();
      squash();
      test_noskid();
      test_async_reset();
      test_random(4000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
